// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, W clocks per operation.
// Optional macro DIV_SIGNED_EN selects two's-complement operands (default build is unsigned).
module seq_divider #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid holds with stable results until taken.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t          state;
  logic [W-1:0]    rem_r;
  logic [W-1:0]    q_r;
  logic [W-1:0]    dsr_r;
  logic [CNT_W-1:0] cnt;
  logic            neg_q;
  logic            neg_r;

  logic [W:0]      trial;
  logic [W-1:0]    rem_nxt;
  logic [W-1:0]    q_nxt;
  logic [W-1:0]    q_fin;
  logic [W-1:0]    r_fin;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic            a_neg;
  logic            b_neg;

  always_comb begin
    trial   = {rem_r, q_r[W-1]} - {1'b0, dsr_r};
    rem_nxt = {rem_r[W-2:0], q_r[W-1]};
    q_nxt   = {q_r[W-2:0], 1'b0};
    if (!trial[W]) begin
      rem_nxt = trial[W-1:0];
      q_nxt   = {q_r[W-2:0], 1'b1};
    end
  end

`ifdef DIV_SIGNED_EN
  // Magnitude of the most-negative value is itself, which reads correctly as unsigned.
  always_comb begin
    a_neg = dividend[W-1];
    b_neg = divisor[W-1];
    a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    q_fin = neg_q ? (~q_nxt + 1'b1) : q_nxt;
    r_fin = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end
`else
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    a_mag = dividend;
    b_mag = divisor;
    q_fin = q_nxt;
    r_fin = rem_nxt;
  end
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_r       <= '0;
      q_r         <= '0;
      dsr_r       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              rem_r       <= '0;
              q_r         <= a_mag;
              dsr_r       <= b_mag;
              neg_q       <= a_neg ^ b_neg;
              neg_r       <= a_neg;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          rem_r <= rem_nxt;
          q_r   <= q_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (W=16): latency, results, divide-by-zero, back-pressure, reset.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.W(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one accept edge; leaves the bench 1 time unit after that edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
  endtask

  // Counts clocks after the accept edge until out_valid, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                       input int elat);
    int cyc;
    accept(a, b);
    wait_done(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(elat));
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    release_result(tag);
  endtask

  initial begin
    int cyc;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("d100_7", 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0, 16);
    do_op("ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16);
    do_op("5_9", 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 16);
    do_op("dbz", 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 0);
    do_op("dbz_clr", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 16);
    do_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16);
`ifdef DIV_SIGNED_EN
    do_op("s_m7_2", 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 16);
    do_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 16);
    do_op("s_dbz", 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 0);
`else
    do_op("u_8000_ffff", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 16);
`endif

    // Back-pressure in DONE: results stay put and a new request is ignored.
    accept(16'd200, 16'd9);
    wait_done(cyc);
    check("bp_lat", 32'(cyc), 32'd16);
    dividend = 16'd77;
    divisor  = 16'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_q", 32'(quotient), 32'd22);
      check("bp_r", 32'(remainder), 32'd2);
      check("bp_dbz", 32'(div_by_zero), 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_q_keep", 32'(quotient), 32'd22);
    check("bp_r_keep", 32'(remainder), 32'd2);
    tick();
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a run discards the operation.
    accept(16'd999, 16'd4);
    repeat (8) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_ov", 32'(out_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_q", 32'(quotient), 32'd0);
    check("mr_r", 32'(remainder), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_stays_idle", 32'(out_valid), 32'd0);
    do_op("d50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
